// File: rtl/byte_decode_stream_pkg.sv
// Shared constants and elaboration helpers for the ByteDecode/decompress
// datapath.
//   KYBER_Q  : modulus used by decompress
//   KYBER_N  : coefficients per polynomial
//   COEFF_W  : width of a decompressed coefficient
//   legal_d  : true for the compressed field widths Kyber uses
package byte_decode_stream_pkg;

  localparam int KYBER_Q = 3329;
  localparam int KYBER_N = 256;
  localparam int COEFF_W = 12;

  function automatic bit legal_d(input int d);
    return (d == 1) || (d == 4) || (d == 5) || (d == 10) || (d == 11);
  endfunction

endpackage

// File: rtl/byte_decode_stream_if.sv
// Byte-in / coefficient-out stream bundle for byte_decode_stream.
//   in_data/in_valid/in_ready          : packed ciphertext bytes
//   out_coeff/out_idx/out_last/out_valid/out_ready : decompressed coefficients
// Handshake: a beat transfers on a rising clk edge where valid && ready are
// both high. The source holds its payload stable while valid is high and
// ready is low; the sink may raise or drop ready at any time.
// Modports: slave = the decoder, master = the byte producer / coeff consumer.
interface byte_decode_stream_if;
  import byte_decode_stream_pkg::*;

  logic [7:0]         in_data;
  logic               in_valid;
  logic               in_ready;
  logic [COEFF_W-1:0] out_coeff;
  logic [7:0]         out_idx;
  logic               out_last;
  logic               out_valid;
  logic               out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_coeff, out_idx, out_last, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_coeff, out_idx, out_last, out_valid
  );

endinterface

// File: rtl/byte_decode_stream_decompress.sv
// Kyber decompress_D: coeff = round(KYBER_Q * y / 2^D), ties rounded up.
//   y     : D-bit compressed field
//   coeff : 12-bit coefficient in [0, KYBER_Q-1]
module byte_decode_stream_decompress
  import byte_decode_stream_pkg::*;
#(
  parameter int D = 10
) (
  input  logic [D-1:0]       y,
  output logic [COEFF_W-1:0] coeff
);

  // KYBER_Q < 2^12, so KYBER_Q*y plus the half-LSB rounding term fits in
  // D+13 bits; after the shift the result always fits in 12 bits.
  localparam int PW = D + 13;
  localparam logic [PW-1:0] HALF = PW'(1) << (D - 1);

  assign coeff = COEFF_W'((PW'(KYBER_Q) * PW'(y) + HALF) >> D);

endmodule

// File: rtl/byte_decode_stream.sv
// ByteDecode_D unpacker + decompress. Accepts packed ciphertext bytes and
// emits one decompressed coefficient per output handshake, slicing D-bit
// fields LSB-first and numbering them 0..N-1 within each polynomial.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : byte_decode_stream_if.slave (byte input, coefficient output)
// The only state is a bit buffer, its fill level and the coefficient index.
// A byte is accepted only while fewer than D bits are buffered and a
// coefficient is offered only while at least D are, so the two sides never
// transfer in the same cycle and the buffer never needs more than D+7 bits.
module byte_decode_stream
  import byte_decode_stream_pkg::*;
#(
  parameter int D = 10,
  parameter int N = KYBER_N
) (
  input  logic                 clk,
  input  logic                 rst,
  byte_decode_stream_if.slave  bus
);

  localparam int BW = D + 7;
  localparam int FW = $clog2(D + 8);

  if (!legal_d(D)) begin : g_illegal_d
    $error("byte_decode_stream: D=%0d is not a legal field width", D);
  end
  if (N < 1 || N > 256 || ((N * D) % 8) != 0) begin : g_illegal_n
    $error("byte_decode_stream: N=%0d must be 1..256 with N*D a multiple of 8", N);
  end

  logic [BW-1:0] bit_buf;
  logic [FW-1:0] fill;
  logic [7:0]    idx;
  logic          in_xfer;
  logic          out_xfer;

  assign bus.in_ready  = !rst && (fill < FW'(D));
  assign bus.out_valid = (fill >= FW'(D));
  assign bus.out_idx   = idx;
  assign bus.out_last  = bus.out_valid && (idx == 8'(N - 1));

  assign in_xfer  = bus.in_valid && bus.in_ready;
  assign out_xfer = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_buf <= '0;
      fill    <= '0;
      idx     <= '0;
    end else if (in_xfer) begin
      // New byte lands directly above the bits still waiting in the buffer.
      bit_buf <= bit_buf | (BW'(bus.in_data) << fill);
      fill    <= fill + FW'(8);
    end else if (out_xfer) begin
      bit_buf <= bit_buf >> D;
      fill    <= fill - FW'(D);
      idx     <= (idx == 8'(N - 1)) ? 8'd0 : idx + 8'd1;
    end
  end

  byte_decode_stream_decompress #(.D(D)) u_decompress (
    .y     (bit_buf[D-1:0]),
    .coeff (bus.out_coeff)
  );

endmodule

// File: tb/tb_byte_decode_stream.sv
// Bench for byte_decode_stream: one instance per field width (1,4,5,10,11)
// sharing the input drive; sel picks which instance is observed.
module tb_byte_decode_stream;
  import byte_decode_stream_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  in_data   = 8'h00;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  int          sel       = 11;

  logic        in_ready_o, out_valid_o, out_last_o;
  logic [11:0] out_coeff_o;
  logic [7:0]  out_idx_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [11:0] exp_q[$];
  logic [7:0]  stream[0:703];

  byte_decode_stream_if bus_d1();
  byte_decode_stream_if bus_d4();
  byte_decode_stream_if bus_d5();
  byte_decode_stream_if bus_d10();
  byte_decode_stream_if bus_d11();

  assign bus_d1.in_data  = in_data; assign bus_d1.in_valid  = in_valid; assign bus_d1.out_ready  = out_ready;
  assign bus_d4.in_data  = in_data; assign bus_d4.in_valid  = in_valid; assign bus_d4.out_ready  = out_ready;
  assign bus_d5.in_data  = in_data; assign bus_d5.in_valid  = in_valid; assign bus_d5.out_ready  = out_ready;
  assign bus_d10.in_data = in_data; assign bus_d10.in_valid = in_valid; assign bus_d10.out_ready = out_ready;
  assign bus_d11.in_data = in_data; assign bus_d11.in_valid = in_valid; assign bus_d11.out_ready = out_ready;

  byte_decode_stream #(.D(1))  dut_d1  (.clk(clk), .rst(rst), .bus(bus_d1));
  byte_decode_stream #(.D(4))  dut_d4  (.clk(clk), .rst(rst), .bus(bus_d4));
  byte_decode_stream #(.D(5))  dut_d5  (.clk(clk), .rst(rst), .bus(bus_d5));
  byte_decode_stream #(.D(10)) dut_d10 (.clk(clk), .rst(rst), .bus(bus_d10));
  byte_decode_stream #(.D(11)) dut_d11 (.clk(clk), .rst(rst), .bus(bus_d11));

  always_comb begin
    in_ready_o  = bus_d11.in_ready;  out_valid_o = bus_d11.out_valid; out_last_o = bus_d11.out_last;
    out_coeff_o = bus_d11.out_coeff; out_idx_o   = bus_d11.out_idx;
    case (sel)
      1: begin in_ready_o = bus_d1.in_ready; out_valid_o = bus_d1.out_valid; out_last_o = bus_d1.out_last;
               out_coeff_o = bus_d1.out_coeff; out_idx_o = bus_d1.out_idx; end
      4: begin in_ready_o = bus_d4.in_ready; out_valid_o = bus_d4.out_valid; out_last_o = bus_d4.out_last;
               out_coeff_o = bus_d4.out_coeff; out_idx_o = bus_d4.out_idx; end
      5: begin in_ready_o = bus_d5.in_ready; out_valid_o = bus_d5.out_valid; out_last_o = bus_d5.out_last;
               out_coeff_o = bus_d5.out_coeff; out_idx_o = bus_d5.out_idx; end
      10: begin in_ready_o = bus_d10.in_ready; out_valid_o = bus_d10.out_valid; out_last_o = bus_d10.out_last;
                out_coeff_o = bus_d10.out_coeff; out_idx_o = bus_d10.out_idx; end
      default: ;
    endcase
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // round(q*y/2^d) with ties up, written as an exact integer division.
  function automatic int golden(input int d, input int y);
    return (2 * KYBER_Q * y + (1 << d)) / (1 << (d + 1));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int d_sel);
    @(negedge clk);
    sel = d_sel; rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    @(negedge clk);
    #1;
    check("rst_in_ready_low", 32'(in_ready_o), 0);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid_o), 0);
    check("rst_out_last", 32'(out_last_o), 0);
    check("rst_out_coeff", 32'(out_coeff_o), 0);
    check("rst_out_idx", 32'(out_idx_o), 0);
    check("rst_in_ready_high", 32'(in_ready_o), 1);
  endtask

  // Streams stream[0..nbytes-1] into the selected instance and scores the
  // first target coefficients against the golden decode of that stream.
  task automatic run_stream(input int d, input int nbytes, input int target, input bit gaps);
    int bi;
    int ci;
    logic [11:0] exp_c;
    bi = 0;
    ci = 0;
    exp_q.delete();
    for (int i = 0; i < target; i++) begin
      int y;
      y = 0;
      for (int b = 0; b < d; b++) begin
        int k;
        logic [7:0] byte_v;
        k = i * d + b;
        byte_v = stream[k / 8];
        y = y | (int'(byte_v[k % 8]) << b);
      end
      exp_q.push_back(12'(golden(d, y)));
    end
    for (int cyc = 0; cyc < 8000 && ci < target; cyc++) begin
      @(negedge clk);
      in_valid  = (bi < nbytes) && (!gaps || $urandom_range(0, 3) != 0);
      in_data   = (bi < nbytes) ? stream[bi] : 8'h00;
      out_ready = !gaps || ($urandom_range(0, 2) != 0);
      #1;
      check("stream_in_out_exclusive", 32'(in_ready_o && out_valid_o), 0);
      if (in_valid && in_ready_o) bi++;
      if (out_valid_o && out_ready) begin
        exp_c = exp_q.pop_front();
        check("stream_coeff", 32'(out_coeff_o), 32'(exp_c));
        check("stream_idx", 32'(out_idx_o), ci % 256);
        check("stream_last", 32'(out_last_o), 32'((ci % 256) == 255));
        ci++;
      end else if (!out_valid_o) begin
        check("stream_last_idle", 32'(out_last_o), 0);
      end
    end
    check("stream_coeff_count", ci, target);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic [3:0]        d;
    logic [1:0]        nbytes;
    logic [0:1][7:0]   bytes;
    logic [3:0]        ncoef;
    logic [0:7][11:0]  exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int acc, ci, fill_m, d, nb, nc;
    vecs[0] = '{d: 4'd1,  nbytes: 2'd1, bytes: {8'hA5, 8'h00}, ncoef: 4'd8,
                exp: {12'd1665, 12'd0, 12'd1665, 12'd0, 12'd0, 12'd1665, 12'd0, 12'd1665}};
    vecs[1] = '{d: 4'd4,  nbytes: 2'd1, bytes: {8'h3C, 8'h00}, ncoef: 4'd2,
                exp: {12'd2497, 12'd624, 72'd0}};
    vecs[2] = '{d: 4'd10, nbytes: 2'd2, bytes: {8'hFF, 8'h03}, ncoef: 4'd1,
                exp: {12'd3326, 84'd0}};
    vecs[3] = '{d: 4'd10, nbytes: 2'd2, bytes: {8'h00, 8'h02}, ncoef: 4'd1,
                exp: {12'd1665, 84'd0}};
    vecs[4] = '{d: 4'd5,  nbytes: 2'd2, bytes: {8'hE3, 8'h00}, ncoef: 4'd3,
                exp: {12'd312, 12'd728, 12'd0, 60'd0}};
    vecs[5] = '{d: 4'd11, nbytes: 2'd2, bytes: {8'hFF, 8'h07}, ncoef: 4'd1,
                exp: {12'd3327, 84'd0}};

    for (int v = 0; v < 6; v++) begin
      d  = int'(vecs[v].d);
      nb = int'(vecs[v].nbytes);
      nc = int'(vecs[v].ncoef);
      do_reset(d);
      acc = 0;
      ci  = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
        @(negedge clk);
        fill_m    = acc * 8 - ci * d;
        in_valid  = (acc < nb);
        in_data   = (acc < nb) ? vecs[v].bytes[acc] : 8'h00;
        out_ready = 1'b1;
        #1;
        check("vec_in_ready", 32'(in_ready_o), 32'(fill_m < d));
        check("vec_out_valid", 32'(out_valid_o), 32'(fill_m >= d));
        if (in_valid && in_ready_o) begin
          acc++;
        end else if (out_valid_o) begin
          if (ci < 8) check("vec_coeff", 32'(out_coeff_o), 32'(vecs[v].exp[ci]));
          check("vec_idx", 32'(out_idx_o), ci);
          ci++;
        end
        if (acc == nb && ci == nc) break;
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      fill_m = acc * 8 - ci * d;
      check("vec_in_ready_after", 32'(in_ready_o), 32'(fill_m < d));
      check("vec_coeff_count", ci, nc);
    end

    // Backpressure: coefficient held for 10 cycles, no byte accepted.
    do_reset(4);
    @(negedge clk);
    in_data = 8'h3C; in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("bp_out_valid", 32'(out_valid_o), 1);
      check("bp_coeff", 32'(out_coeff_o), 2497);
      check("bp_idx", 32'(out_idx_o), 0);
      check("bp_in_ready", 32'(in_ready_o), 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("bp_release_coeff0", 32'(out_coeff_o), 2497);
    @(negedge clk);
    #1;
    check("bp_coeff1", 32'(out_coeff_o), 624);
    check("bp_idx1", 32'(out_idx_o), 1);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("bp_drained_valid", 32'(out_valid_o), 0);
    check("bp_drained_in_ready", 32'(in_ready_o), 1);

    // D=11: two polynomials back to back with random gaps on both sides.
    do_reset(11);
    for (int i = 0; i < 704; i++) stream[i] = 8'($urandom_range(0, 255));
    run_stream(11, 704, 512, 1'b1);
    check("d11_fill_zero", 32'(dut_d11.fill), 0);
    check("d11_queue_empty", exp_q.size(), 0);

    // D=5: reset after 37 coefficients, then a fresh polynomial.
    do_reset(5);
    for (int i = 0; i < 160; i++) stream[i] = 8'($urandom_range(0, 255));
    run_stream(5, 160, 37, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready_o), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid_o), 0);
    check("mid_rst_out_last", 32'(out_last_o), 0);
    check("mid_rst_out_coeff", 32'(out_coeff_o), 0);
    check("mid_rst_out_idx", 32'(out_idx_o), 0);
    check("mid_rst_in_ready_high", 32'(in_ready_o), 1);
    for (int i = 0; i < 160; i++) stream[i] = 8'($urandom_range(0, 255));
    run_stream(5, 160, 256, 1'b1);
    check("d5_fill_zero", 32'(dut_d5.fill), 0);

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
